// File: rtl/spi_master_arbiter_if.sv
// Client-side request/grant bus between the on-chip requesters and spi_master_arbiter.
// The requesters drive req/tx_data through the master modport; the arbiter uses the slave modport.
interface spi_master_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] tx_data;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic [7:0]           rx_data;
  logic                 busy;

  modport master (
    output req,
    output tx_data,
    input  grant,
    input  done,
    input  rx_data,
    input  busy
  );

  modport slave (
    input  req,
    input  tx_data,
    output grant,
    output done,
    output rx_data,
    output busy
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// SPI mode-0 master shared by NUM_REQ requesters: one 8-bit transfer per grant, all outputs registered.
// Build option SPI_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise fixed priority (lowest index).
module spi_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic                clk,
  input  logic                reset,
  spi_master_arbiter_if.slave bus,
  output logic                SCLK,
  output logic                CS,
  output logic                MOSI,
  input  logic                MISO
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = (CS_GAP > 0) ? 16'(CS_GAP - 1) : 16'd0;
  // SHIFT walks 15 half-phases: even = SCLK high (bits 0..7), odd = low phase after bits 0..6.
  localparam logic [3:0]  LAST_HALF = 4'd14;

  state_e             state_q, state_d;
  logic [15:0]        div_q, div_d;
  logic [15:0]        gap_q, gap_d;
  logic [3:0]         half_q, half_d;
  logic [7:0]         tx_sh_q, tx_sh_d;
  logic [7:0]         rx_sh_q, rx_sh_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               busy_q, busy_d;
  logic               sclk_q, sclk_d;
  logic               cs_q, cs_d;
  logic               mosi_q, mosi_d;

  logic [NUM_REQ-1:0] win_oh_s;
  logic               found_s;
  logic [7:0]         win_tx_s;

`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;

  function automatic int rr_pos(input logic [2:0] ptr, input int ofs);
    int p;
    p = int'(ptr) + ofs;
    if (p >= NUM_REQ) begin
      p = p - NUM_REQ;
    end else begin
      p = p;
    end
    return p;
  endfunction

  function automatic logic [2:0] next_ptr(input logic [NUM_REQ-1:0] oh);
    logic [2:0] p;
    p = 3'd0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (oh[j]) begin
        p = (j + 1 >= NUM_REQ) ? 3'd0 : 3'(j + 1);
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  // Round-robin search starting at the pointer (last winner + 1).
  always_comb begin
    win_oh_s = '0;
    found_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found_s && bus.req[j] && (j == rr_pos(ptr_q, i))) begin
          win_oh_s[j] = 1'b1;
          found_s     = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Pointer advances only on a grant.
  always_comb begin
    if ((state_q == ST_IDLE) && found_s) begin
      ptr_d = next_ptr(win_oh_s);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Arbitration pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest active index wins.
  always_comb begin
    win_oh_s = '0;
    found_s  = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_s && bus.req[j]) begin
        win_oh_s[j] = 1'b1;
        found_s     = 1'b1;
      end else begin
        win_oh_s[j] = 1'b0;
      end
    end
  end
`endif

  // Winner's transmit byte.
  always_comb begin
    win_tx_s = 8'h00;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win_oh_s[j]) begin
        win_tx_s = bus.tx_data[8*j +: 8];
      end else begin
        win_tx_s = win_tx_s;
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    gap_d     = gap_q;
    half_d    = half_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    grant_d   = grant_q;
    done_d    = '0;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_SETUP;
          grant_d = win_oh_s;
          tx_sh_d = win_tx_s;
          rx_sh_d = 8'h00;
          mosi_d  = win_tx_s[7];
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          div_d   = 16'd0;
          half_d  = 4'd0;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], MISO};
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = 16'd0;
          if (half_q == LAST_HALF) begin
            state_d = ST_HOLD;
            sclk_d  = 1'b0;
          end else if (!half_q[0]) begin
            // Falling edge: present the next bit; rotating keeps it at position 6.
            sclk_d  = 1'b0;
            half_d  = half_q + 4'd1;
            mosi_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[6:0], tx_sh_q[7]};
          end else begin
            sclk_d  = 1'b1;
            half_d  = half_q + 4'd1;
            rx_sh_d = {rx_sh_q[6:0], MISO};
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      ST_HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d   = ST_DONE;
          div_d     = 16'd0;
          cs_d      = 1'b1;
          rx_data_d = rx_sh_q;
          done_d    = grant_q;
          grant_d   = '0;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      ST_DONE: begin
        gap_d = 16'd0;
        if (CS_GAP == 0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= 16'd0;
      gap_q     <= 16'd0;
      half_q    <= 4'd0;
      tx_sh_q   <= 8'h00;
      rx_sh_q   <= 8'h00;
      grant_q   <= '0;
      done_q    <= '0;
      rx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      half_q    <= half_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign SCLK        = sclk_q;
  assign CS          = cs_q;
  assign MOSI        = mosi_q;

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

SPI master and bus arbiter that shares one SPI link among `NUM_REQ` on-chip requesters. It grants one requester at a time and runs a full 8-bit mode-0 transfer on `SCLK`/`CS`/`MOSI`/`MISO`. It returns the received byte to the winning requester. It sits between the system-side clients and the external SPI slave, and owns all SPI timing.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, range 1 to 8.
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period, ≥1.
- `CS_GAP`, default 2: extra `clk` cycles that `CS` stays high between transactions, ≥0.

Ports:
- `clk`, in, 1: system clock. All logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req`, in, `NUM_REQ`: per-requester transfer request. A requester holds it until its `done`.
- `tx_data`, in, `8*NUM_REQ`: byte i is at `[8i+7:8i]`. It is sampled at grant.
- `grant`, out, `NUM_REQ`: one-hot. High for the whole transaction of the winner.
- `done`, out, `NUM_REQ`: one-cycle pulse to the winner at transaction end.
- `rx_data`, out, 8: received byte. Valid in the `done` cycle and held until the next `done`.
- `busy`, out, 1: high from the grant cycle through the end of the gap.
- `SCLK`, out, 1: SPI clock, idle low.
- `CS`, out, 1: active-low chip select, idle high.
- `MOSI`, out, 1: serial data to the slave, MSB first.
- `MISO`, in, 1: serial data from the slave, MSB first.

## Operation
- Reset values: `CS`=1, `SCLK`=0, `MOSI`=0, `grant`=0, `done`=0, `rx_data`=0x00, `busy`=0. The arbitration pointer selects requester 0 first.
- FSM states: IDLE → SETUP → SHIFT → HOLD → DONE → GAP → IDLE.
- IDLE
  - If `req`≠0, arbitrate.
  - Register the one-hot `grant` and latch the winner's `tx_data` into the TX shifter.
  - Go to SETUP.
- SETUP
  - `CS`=0, `SCLK`=0, `MOSI`=bit 7, for `CLK_DIV` cycles.
- SHIFT: 8 bits.
  - Each bit has a high phase of `CLK_DIV` cycles.
  - Bits 0–6 are each followed by a low phase of `CLK_DIV` cycles.
  - On the clk edge that drives `SCLK` 0→1, shift `MISO` into the RX register (mode 0, sample on rising).
  - On each 1→0 transition except the last, `MOSI` advances to the next bit.
- HOLD
  - `SCLK`=0, `CS`=0, `MOSI` unchanged, for `CLK_DIV` cycles.
- DONE: one cycle.
  - `CS`=1 and `rx_data` = RX register.
  - `done[winner]`=1 and `grant`=0.
- GAP
  - `CS`=1 for `CS_GAP` cycles, then IDLE.
- Dropping `req` mid-transaction is ignored: the transfer completes and `done` still pulses.
- Changing `tx_data` after grant has no effect on the transfer.
- New `req` assertions during a transaction are only evaluated in IDLE.
- Reset mid-transaction aborts the transfer.
  - All outputs return to their reset values on the next edge.
  - No `done` is issued.
  - The pointer is reset.

## Timing
- Let G be the first cycle with `grant` high. `grant` registers one cycle after the IDLE cycle that sees `req`.
- Bit k (0..7) has `SCLK` high during cycles G+(2k+1)·`CLK_DIV` through G+(2k+2)·`CLK_DIV`−1.
- The `done` cycle is D = G+17·`CLK_DIV`.
- `CS` is low during cycles G through D−1.
- IDLE is at D+`CS_GAP`+1.
- The earliest next grant is at D+`CS_GAP`+2, so `CS` is high for at least `CS_GAP`+2 cycles between transfers.
- `busy` is high from G through D+`CS_GAP`.

## Configuration
- `SPI_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The search starts at (last winner + 1) mod `NUM_REQ`.
  - The pointer updates at each grant.
- Not defined: fixed priority. The lowest active index always wins, and the pointer logic is not built.

## Test plan
- Single transfer, `CLK_DIV`=4, `req[0]`, `tx_data[7:0]`=0xA5, `MISO` looped from `MOSI`:
  - exactly 8 `SCLK` rising edges;
  - `MOSI` sequence 1,0,1,0,0,1,0,1;
  - `done[0]` at G+68;
  - `rx_data`=0xA5.
- `MISO` pattern 0x3C applied MSB-first, changing on `SCLK` falling edges: `rx_data`=0x3C. With `MISO` tied 1: `rx_data`=0xFF.
- `req`=4'b1111 held for 4 transfers:
  - with `SPI_ARB_ROUND_ROBIN_EN`, grants are 0001, 0010, 0100, 1000;
  - without it, every grant is 0001.
- Back-to-back `req[1]` and `req[2]` with `CS_GAP`=2: `CS` high for exactly 4 cycles between transfers, and `grant` stays one-hot throughout.
- `reset` pulsed during bit 4 of a transfer:
  - next cycle `CS`=1, `SCLK`=0, `grant`=0, with no `done`;
  - the following transfer of 0x5A completes correctly.
- `req[0]` dropped one cycle after grant: the transfer still completes and `done[0]` pulses once at D.
